// File: rtl/uart_rx.sv
// 16x-oversampled 8N1 UART receiver with a 2-FF input synchroniser and error pulses.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits and a parity_err output.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx,
  input  logic            s_tick,
  input  logic            fifo_full,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
`ifdef UART_RX_PARITY_EN
  output logic            parity_err,
`endif
  output logic            overrun_err
);

  // Tick counter is widened only when a long stop period needs more than 4 bits.
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_MID       = SW'(7);
  localparam logic [SW-1:0] S_BIT_LAST  = SW'(15);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic            rx_meta_q;
  logic            rx_s_q;

  logic [2:0]      state_q,  state_d;
  logic [SW-1:0]   s_cnt_q,  s_cnt_d;
  logic [NW-1:0]   n_cnt_q,  n_cnt_d;
  logic [DBIT-1:0] b_q,      b_d;
  logic [DBIT-1:0] dout_q,   dout_d;
  logic            done_q,   done_d;
  logic            ferr_q,   ferr_d;
  logic            ovr_q,    ovr_d;
`ifdef UART_RX_PARITY_EN
  logic            perr_q,   perr_d;
  logic            par_bad_q, par_bad_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end

      START: begin
        if (s_tick) begin
          if (s_cnt_q == S_MID) begin
            // A start bit that is high again at its midpoint was a glitch.
            if (!rx_s_q) begin
              state_d = DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == S_BIT_LAST) begin
            s_cnt_d = '0;
            b_d     = {rx_s_q, b_q[DBIT-1:1]};
            if (n_cnt_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_cnt_d = n_cnt_q + NW'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_cnt_q == S_BIT_LAST) begin
            s_cnt_d   = '0;
            par_bad_d = rx_s_q ^ (^b_q);
            state_d   = STOP;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
`endif

      STOP: begin
        if (s_tick) begin
          if (s_cnt_q == S_STOP_LAST) begin
            state_d = IDLE;
            // A low stop bit outranks every other outcome of the frame.
            if (!rx_s_q) begin
              ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad_q) begin
              perr_d = 1'b1;
`endif
            end else begin
              done_d = 1'b1;
              dout_d = b_q;
              ovr_d  = fifo_full;
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      s_cnt_q   <= '0;
      n_cnt_q   <= '0;
      b_q       <= '0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      s_cnt_q   <= s_cnt_d;
      n_cnt_q   <= n_cnt_d;
      b_q       <= b_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
  assign overrun_err  = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = perr_q;
`endif

endmodule
